rx_frame_buffer: RTL and testbench
==================================

// Module: rx_frame_buffer
// PURPOSE
//  Downstream consumer of the ISO7816 UART receive core. Captures each completed byte
//  (dataOut + dataOutReadyFlag) or errored frame (frameErrorFlag) into a small FIFO.
//  Returns ackFlags to the core and counts frame / overrun / FIFO-overflow events.
//  Presents bytes to the protocol layer (ATR/T=0 engine) over a valid/ready pop port.
// PARAMETERS
//  DEPTH_LOG2     4   FIFO depth = 2**DEPTH_LOG2 entries, each 9 bits {errTag, data[7:0]}
//  ERR_CNT_WIDTH  8   width of each saturating event counter
// PORTS
//  clk              in   1             rising-edge clock, same domain as receive core
//  reset            in   1             synchronous, active-high
//  rxData           in   8             receive core dataOut
//  rxDataReady      in   1             receive core dataOutReadyFlag (level)
//  rxFrameError     in   1             receive core frameErrorFlag (level)
//  rxOverrunError   in   1             receive core overrunErrorFlag (level)
//  rxAckFlags       out  1             to receive core ackFlags; registered
//  storeErrored     in   1             1: errored frames enter FIFO with errTag=1; 0: dropped
//  flush            in   1             empty FIFO in one cycle; counters untouched
//  clearCounters    in   1             zero all three counters
//  popData          out  8             FIFO head data
//  popErrTag        out  1             FIFO head errTag
//  popValid         out  1             FIFO not empty
//  popReady         in   1             consumer accepts head when popValid&popReady
//  fifoLevel        out  DEPTH_LOG2+1  entries held, 0..2**DEPTH_LOG2
//  fifoFull         out  1             fifoLevel == 2**DEPTH_LOG2
//  frameErrCount    out  ERR_CNT_WIDTH frames with frameErrorFlag
//  overrunCount     out  ERR_CNT_WIDTH rising edges of rxOverrunError
//  overflowCount    out  ERR_CNT_WIDTH events lost because FIFO full
// BEHAVIOUR
//  Reset: FSM=IDLE, rxAckFlags=0, FIFO empty (popValid=0, fifoLevel=0, fifoFull=0).
//   All counters=0; overrun edge register=0. popData/popErrTag=0.
//  FSM IDLE:
//   - Event = rxDataReady | rxFrameError, sampled at edge N.
//   - rxFrameError has priority if both are high: entry {1,rxData}, frameErrCount+1.
//     Pushed only if storeErrored.
//   - Otherwise entry {0,rxData} pushed.
//   - On event: go ACK; rxAckFlags=1 from cycle N+1.
//  FSM ACK:
//   - rxAckFlags held 1 while rxDataReady|rxFrameError is high.
//   - When both are low: rxAckFlags=0, return IDLE. No new capture while in ACK.
//   - Nominal: flags low at N+2; one byte per >=3 cycles, far above line rate.
//  Push rule:
//   - Accepted if !fifoFull, or if a pop occurs in the same cycle.
//   - Otherwise dropped and overflowCount+1; the flags are still acked.
//  Pop: head advances on popValid&popReady; popReady while empty is ignored.
//  Simultaneous push+pop: fifoLevel unchanged, pointers both advance.
//   Head data is stable while popValid&~popReady.
//  Pointers: DEPTH_LOG2+1 bits, wrap naturally; full = MSB differ and rest equal.
//  Overrun: overrunCount+1 on each 0->1 of rxOverrunError (registered edge detect).
//   Nothing pushed for the lost byte.
//  Counters: saturate at all-ones, never wrap.
//   clearCounters wins over an increment in the same cycle.
//  flush: pointers zeroed; a push in the same cycle is discarded and not counted as overflow.
//   FSM/ack unaffected.
//  Reset mid-ACK: rxAckFlags drops next edge. The core keeps its flag and is re-captured
//   after reset as a new event.
// STRUCTURE
//  Shared package: FIFO entry layout (ERR_TAG_BIT=8), FSM encodings
//   (RXB_IDLE=1'b0, RXB_ACK=1'b1).
//  One sub-module: sync_fifo (params WIDTH=9, DEPTH_LOG2; push/pop/flush/level/full).
//   Reusable by the transmit side.
//  Top: FSM, ack register, edge detect, three saturating counters.
// TESTING
//  1. Core model presents 0x3B ready at N -> rxAckFlags=1 at N+1 only.
//     popValid=1, popData=0x3B, popErrTag=0, fifoLevel=1.
//  2. Frame error with rxData=0xA5, storeErrored=1 -> entry {1,0xA5}, frameErrCount=1.
//     Repeat with storeErrored=0 -> FIFO unchanged, frameErrCount=2.
//  3. DEPTH_LOG2=2: push 5 bytes with no pop -> fifoFull=1, level=4, overflowCount=1.
//     All 5 acked; pop order is bytes 1..4.
//  4. Full FIFO with popReady=1 in the capture cycle -> push accepted, level stays 4,
//     overflowCount unchanged.
//  5. rxOverrunError held high 10 cycles, then pulsed twice -> overrunCount=3.
//     Counters at 255 stay 255; clearCounters with a concurrent event -> 0.
//  6. Reset asserted during ACK with rxDataReady held -> rxAckFlags=0 and level=0 next edge.
//     After release the byte is captured once and acked.

Source files
------------

// File: rtl/rx_frame_buffer_pkg.sv
// Shared definitions for the receive frame buffer: FIFO entry layout and FSM encodings.
// Pure declarations, no logic.
package rx_frame_buffer_pkg;
   localparam int DATA_W      = 8;
   localparam int ERR_TAG_BIT = 8;
   localparam int ENTRY_W     = 9;

   typedef enum logic {
      RXB_IDLE = 1'b0,
      RXB_ACK  = 1'b1
   } rxb_state_e;

   typedef struct packed {
      logic              err_tag;
      logic [DATA_W-1:0] data;
   } rxb_entry_t;
endpackage

// File: rtl/rx_frame_buffer_if.sv
// Bundle of receive-core, control, pop-port and statistics signals of the frame buffer.
// slave = buffer side, master = receive core / consumer side.
interface rx_frame_buffer_if #(
   parameter int DEPTH_LOG2    = 4,
   parameter int ERR_CNT_WIDTH = 8
) ();
   logic [7:0]               rxData;
   logic                     rxDataReady;
   logic                     rxFrameError;
   logic                     rxOverrunError;
   logic                     rxAckFlags;
   logic                     storeErrored;
   logic                     flush;
   logic                     clearCounters;
   logic [7:0]               popData;
   logic                     popErrTag;
   logic                     popValid;
   logic                     popReady;
   logic [DEPTH_LOG2:0]      fifoLevel;
   logic                     fifoFull;
   logic [ERR_CNT_WIDTH-1:0] frameErrCount;
   logic [ERR_CNT_WIDTH-1:0] overrunCount;
   logic [ERR_CNT_WIDTH-1:0] overflowCount;

   modport slave (
      input  rxData, rxDataReady, rxFrameError, rxOverrunError,
      input  storeErrored, flush, clearCounters, popReady,
      output rxAckFlags, popData, popErrTag, popValid, fifoLevel, fifoFull,
      output frameErrCount, overrunCount, overflowCount
   );

   modport master (
      output rxData, rxDataReady, rxFrameError, rxOverrunError,
      output storeErrored, flush, clearCounters, popReady,
      input  rxAckFlags, popData, popErrTag, popValid, fifoLevel, fifoFull,
      input  frameErrCount, overrunCount, overflowCount
   );
endinterface

// File: rtl/rx_frame_buffer_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; write lands one edge after push, head is combinational.
// A push into a full FIFO is accepted only when a pop happens in the same cycle, otherwise o_drop.
module sync_fifo #(
   parameter int WIDTH      = 9,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_push,
   input  logic [WIDTH-1:0]    i_push_dat,
   input  logic                i_pop,
   input  logic                i_flush,
   output logic [WIDTH-1:0]    o_head_dat,
   output logic                o_vld,
   output logic                o_full,
   output logic [DEPTH_LOG2:0] o_level,
   output logic                o_drop
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

   logic [WIDTH-1:0]    r_mem [DEPTH];
   logic [DEPTH_LOG2:0] r_wr_ptr;
   logic [DEPTH_LOG2:0] r_rd_ptr;
   logic                w_empty;
   logic                w_pop_ok;
   logic                w_push_ok;

   assign w_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                      (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
   assign w_pop_ok  = i_pop & ~w_empty;
   // a flush swallows a concurrent push without calling it an overflow
   assign w_push_ok = i_push & ~i_flush & (~o_full | w_pop_ok);
   assign o_drop    = i_push & ~i_flush & o_full & ~w_pop_ok;
   assign o_level   = r_wr_ptr - r_rd_ptr;
   assign o_vld     = ~w_empty;
   assign o_head_dat = w_empty ? '0 : r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];

   always_ff @(posedge clk) begin
      if (reset || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= i_push_dat;
   end
endmodule

// File: rtl/rx_frame_buffer.sv
// Captures bytes / errored frames from the UART receive core into a FIFO, acks the core, counts events.
// Capture on the first edge a flag is seen, ack registered from the next cycle; consumer pops via valid/ready.
import rx_frame_buffer_pkg::*;

module rx_frame_buffer #(
   parameter int DEPTH_LOG2    = 4,
   parameter int ERR_CNT_WIDTH = 8
) (
   input logic              clk,
   input logic              reset,
   rx_frame_buffer_if.slave bus
);
   localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [ERR_CNT_WIDTH-1:0] CNT_ONE = {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};

   rxb_state_e           r_state;
   rxb_state_e           w_state_nxt;
   logic                 r_ack;
   logic                 w_ack_nxt;
   logic                 w_capture;
   logic                 w_evt;
   logic                 w_push;
   logic                 w_frame_err;
   logic                 w_drop;
   logic                 r_ovr_d;
   logic                 w_ovr_rise;
   rxb_entry_t           w_entry;
   logic [ENTRY_W-1:0]   w_head;
   logic [ERR_CNT_WIDTH-1:0] r_frame_cnt;
   logic [ERR_CNT_WIDTH-1:0] r_ovr_cnt;
   logic [ERR_CNT_WIDTH-1:0] r_ovf_cnt;

   assign w_evt = bus.rxDataReady | bus.rxFrameError;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= RXB_IDLE;
         r_ack   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ack   <= w_ack_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ack_nxt   = 1'b0;
      w_capture   = 1'b0;
      case (r_state)
         RXB_IDLE: begin
            if (w_evt) begin
               w_state_nxt = RXB_ACK;
               w_ack_nxt   = 1'b1;
               w_capture   = 1'b1;
            end
         end
         RXB_ACK: begin
            // hold the ack until the core has dropped both flags
            if (w_evt) w_ack_nxt = 1'b1;
            else       w_state_nxt = RXB_IDLE;
         end
      endcase
   end

   assign w_frame_err = w_capture & bus.rxFrameError;
   assign w_push      = w_capture & (~bus.rxFrameError | bus.storeErrored);
   assign w_entry     = '{err_tag: bus.rxFrameError, data: bus.rxData};
   assign w_ovr_rise  = bus.rxOverrunError & ~r_ovr_d;

   sync_fifo #(
      .WIDTH      (ENTRY_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .i_push     (w_push),
      .i_push_dat (w_entry),
      .i_pop      (bus.popReady),
      .i_flush    (bus.flush),
      .o_head_dat (w_head),
      .o_vld      (bus.popValid),
      .o_full     (bus.fifoFull),
      .o_level    (bus.fifoLevel),
      .o_drop     (w_drop)
   );

   assign bus.popData    = w_head[7:0];
   assign bus.popErrTag  = w_head[ERR_TAG_BIT];
   assign bus.rxAckFlags = r_ack;

   always_ff @(posedge clk) begin
      if (reset) r_ovr_d <= 1'b0;
      else       r_ovr_d <= bus.rxOverrunError;
   end

   always_ff @(posedge clk) begin
      if (reset || bus.clearCounters) begin
         r_frame_cnt <= '0;
         r_ovr_cnt   <= '0;
         r_ovf_cnt   <= '0;
      end else begin
         if (w_frame_err && r_frame_cnt != CNT_MAX) r_frame_cnt <= r_frame_cnt + CNT_ONE;
         if (w_ovr_rise  && r_ovr_cnt   != CNT_MAX) r_ovr_cnt   <= r_ovr_cnt + CNT_ONE;
         if (w_drop      && r_ovf_cnt   != CNT_MAX) r_ovf_cnt   <= r_ovf_cnt + CNT_ONE;
      end
   end

   assign bus.frameErrCount = r_frame_cnt;
   assign bus.overrunCount  = r_ovr_cnt;
   assign bus.overflowCount = r_ovf_cnt;
endmodule

// File: tb/tb_rx_frame_buffer.sv
// Directed bench for rx_frame_buffer (4-entry FIFO): scoreboard queue of expected pops, negedge monitor.
module tb_rx_frame_buffer;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad = 0;
   int   n_ack;
   logic [8:0] exp_q [$];
   logic [8:0] exp_e;

   always #5 clk = ~clk;

   rx_frame_buffer_if #(.DEPTH_LOG2(2), .ERR_CNT_WIDTH(8)) bus ();

   rx_frame_buffer #(.DEPTH_LOG2(2), .ERR_CNT_WIDTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // core model: drops its flags as soon as it sees the ack; counts ack cycles
   task automatic wait_ack(output int n);
      n = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         bus.popReady = 1'b0;
         bus.flush = 1'b0;
         bus.clearCounters = 1'b0;
         if (bus.rxAckFlags) begin
            n++;
            bus.rxDataReady = 1'b0;
            bus.rxFrameError = 1'b0;
         end
      end
   endtask

   task automatic send(input logic [7:0] d, input logic ferr, input logic pop_cap,
                       input logic flush_cap, output int n);
      bus.rxData = d;
      bus.rxDataReady = ~ferr;
      bus.rxFrameError = ferr;
      bus.popReady = pop_cap;
      bus.flush = flush_cap;
      wait_ack(n);
   endtask

   task automatic drain();
      bus.popReady = 1'b1;
      for (int i = 0; i < 8 && bus.popValid; i++) step();
      bus.popReady = 1'b0;
      check("drain_empty", 32'(bus.popValid), 0);
   endtask

   always @(negedge clk) begin
      if (!reset && bus.popValid && bus.popReady) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pop_unexpected: got %0h expected none", {bus.popErrTag, bus.popData});
         end else begin
            exp_e = exp_q.pop_front();
            check("pop_entry", 32'({bus.popErrTag, bus.popData}), 32'(exp_e));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      bus.rxData = 8'h00;
      bus.rxDataReady = 1'b0;
      bus.rxFrameError = 1'b0;
      bus.rxOverrunError = 1'b0;
      bus.storeErrored = 1'b1;
      bus.flush = 1'b0;
      bus.clearCounters = 1'b0;
      bus.popReady = 1'b0;
      repeat (3) step();
      check("rst_ack", 32'(bus.rxAckFlags), 0);
      check("rst_valid", 32'(bus.popValid), 0);
      check("rst_level", 32'(bus.fifoLevel), 0);
      check("rst_full", 32'(bus.fifoFull), 0);
      check("rst_data", 32'({bus.popErrTag, bus.popData}), 0);
      check("rst_cnts", 32'({bus.frameErrCount, bus.overrunCount, bus.overflowCount}), 0);
      reset = 1'b0;
      step();

      // plain byte
      exp_q.push_back(9'h03B);
      send(8'h3B, 1'b0, 1'b0, 1'b0, n_ack);
      check("t1_ack_cycles", n_ack, 1);
      check("t1_valid", 32'(bus.popValid), 1);
      check("t1_head", 32'({bus.popErrTag, bus.popData}), 32'h03B);
      check("t1_level", 32'(bus.fifoLevel), 1);

      // frame errors, stored then dropped
      exp_q.push_back(9'h1A5);
      send(8'hA5, 1'b1, 1'b0, 1'b0, n_ack);
      check("t2_ack_cycles", n_ack, 1);
      check("t2_level", 32'(bus.fifoLevel), 2);
      check("t2_ferr_cnt", 32'(bus.frameErrCount), 1);
      bus.storeErrored = 1'b0;
      send(8'hA5, 1'b1, 1'b0, 1'b0, n_ack);
      check("t2b_level", 32'(bus.fifoLevel), 2);
      check("t2b_ferr_cnt", 32'(bus.frameErrCount), 2);
      bus.storeErrored = 1'b1;
      drain();

      // five bytes into four entries
      for (int i = 1; i <= 5; i++) begin
         if (i <= 4) exp_q.push_back({1'b0, 8'(i * 8'h11)});
         send(8'(i * 8'h11), 1'b0, 1'b0, 1'b0, n_ack);
         check("t3_ack_cycles", n_ack, 1);
      end
      check("t3_full", 32'(bus.fifoFull), 1);
      check("t3_level", 32'(bus.fifoLevel), 4);
      check("t3_ovf_cnt", 32'(bus.overflowCount), 1);

      // full FIFO, pop in capture cycle
      exp_q.push_back(9'h066);
      send(8'h66, 1'b0, 1'b1, 1'b0, n_ack);
      check("t4_ack_cycles", n_ack, 1);
      check("t4_level", 32'(bus.fifoLevel), 4);
      check("t4_ovf_cnt", 32'(bus.overflowCount), 1);
      drain();

      // overrun edges
      bus.rxOverrunError = 1'b1;
      repeat (10) step();
      for (int i = 0; i < 2; i++) begin
         bus.rxOverrunError = 1'b0;
         step();
         bus.rxOverrunError = 1'b1;
         step();
      end
      bus.rxOverrunError = 1'b0;
      step();
      check("t5_ovr_cnt", 32'(bus.overrunCount), 3);
      for (int i = 0; i < 258; i++) begin
         bus.rxOverrunError = 1'b1;
         step();
         bus.rxOverrunError = 1'b0;
         step();
      end
      check("t5_ovr_sat", 32'(bus.overrunCount), 255);

      // clear with concurrent overrun edge and frame error
      bus.storeErrored = 1'b0;
      bus.clearCounters = 1'b1;
      bus.rxOverrunError = 1'b1;
      send(8'h5A, 1'b1, 1'b0, 1'b0, n_ack);
      bus.rxOverrunError = 1'b0;
      bus.storeErrored = 1'b1;
      check("t5_clr_ovr", 32'(bus.overrunCount), 0);
      check("t5_clr_ferr", 32'(bus.frameErrCount), 0);
      check("t5_clr_ovf", 32'(bus.overflowCount), 0);

      // flush with concurrent push
      send(8'h01, 1'b0, 1'b0, 1'b0, n_ack);
      send(8'h02, 1'b0, 1'b0, 1'b0, n_ack);
      check("fl_level_pre", 32'(bus.fifoLevel), 2);
      send(8'h03, 1'b0, 1'b0, 1'b1, n_ack);
      check("fl_ack_cycles", n_ack, 1);
      check("fl_level", 32'(bus.fifoLevel), 0);
      check("fl_valid", 32'(bus.popValid), 0);
      check("fl_ovf_cnt", 32'(bus.overflowCount), 0);

      // reset in the middle of an ack
      bus.rxData = 8'h77;
      bus.rxDataReady = 1'b1;
      step();
      check("t6_ack_pre", 32'(bus.rxAckFlags), 1);
      check("t6_level_pre", 32'(bus.fifoLevel), 1);
      reset = 1'b1;
      step();
      check("t6_ack_rst", 32'(bus.rxAckFlags), 0);
      check("t6_level_rst", 32'(bus.fifoLevel), 0);
      reset = 1'b0;
      exp_q.push_back(9'h077);
      wait_ack(n_ack);
      check("t6_ack_cycles", n_ack, 1);
      check("t6_level", 32'(bus.fifoLevel), 1);
      drain();

      check("sb_empty", 32'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
